// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
// Holds the FSM encoding, bus widths, the timeout default and a saturating counter helper.
package apb_ctrl_pkg;

    localparam int NUM_REQ         = 2;
    localparam int ADDR_W          = 32;
    localparam int DATA_W          = 32;
    localparam int TIMEOUT_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef struct packed {
        logic              write;
        logic              id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } xfer_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: on a tie the requester not granted last time wins.
// Latency: combinational; backpressure: none, the pointer register lives in the parent.
module apb_rr_arbiter
    import apb_ctrl_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic               last_grant,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        grant = '0;
        if (req == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
        end else begin
            grant = req;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Arbitrates two requesters onto one APB master port with an ACCESS-phase timeout.
// Latency: 3 cycles per transfer minimum; backpressure: req_ready only in IDLE, responses unbuffered.
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic                      apb_clk,
    input  logic                      apb_resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic                      rsp_valid,
    output logic                      rsp_id,
    output logic                      rsp_err,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic [ADDR_W-1:0]         apb_paddr,
    output logic [DATA_W-1:0]         apb_pwdata,
    output logic                      apb_psel,
    output logic                      apb_penable,
    output logic                      apb_pwrite,
    input  logic [DATA_W-1:0]         apb_prdata,
    input  logic                      apb_pready,
    input  logic                      apb_pslverr,
    output logic [15:0]               err_count
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    apb_state_t         state;
    apb_state_t         state_nxt;
    logic               last_grant;
    logic [NUM_REQ-1:0] grant;
    logic               grant_id;
    logic               accept;
    logic               pready_hit;
    logic               timeout_hit;
    logic [7:0]         acc_cnt;
    xfer_t              xfer;

    apb_rr_arbiter u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Gated by reset so req_ready is 0 while reset is held, even with requests pending.
    assign req_ready   = (state == IDLE && apb_resetn) ? grant : '0;
    assign accept      = |(req_valid & req_ready);
    assign grant_id    = grant[1];
    assign pready_hit  = (state == ACCESS) && apb_pready;
    assign timeout_hit = (state == ACCESS) && !apb_pready && (acc_cnt == TO_LIMIT);

    assign apb_psel    = (state != IDLE);
    assign apb_penable = (state == ACCESS);
    assign apb_paddr   = xfer.addr;
    assign apb_pwdata  = xfer.wdata;
    assign apb_pwrite  = xfer.write;

    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (pready_hit || timeout_hit) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge apb_clk or negedge apb_resetn) begin
        if (!apb_resetn) begin
            last_grant <= 1'b1;
            xfer       <= '0;
            acc_cnt    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            err_count  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;

            if (accept) begin
                last_grant <= grant_id;
                xfer.id    <= grant_id;
                xfer.write <= req_write[grant_id];
                xfer.addr  <= grant_id ? req_addr[2*ADDR_W-1:ADDR_W]  : req_addr[ADDR_W-1:0];
                xfer.wdata <= grant_id ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
            end

            if (state == SETUP) begin
                acc_cnt <= 8'd1;
            end else if (state == ACCESS) begin
                acc_cnt <= acc_cnt + 8'd1;
            end

            // pready in the final allowed cycle wins over the timeout.
            if (pready_hit) begin
                rsp_valid <= 1'b1;
                rsp_id    <= xfer.id;
                rsp_err   <= apb_pslverr;
                rsp_rdata <= xfer.write ? '0 : apb_prdata;
                if (apb_pslverr) err_count <= sat_inc16(err_count);
            end else if (timeout_hit) begin
                rsp_valid <= 1'b1;
                rsp_id    <= xfer.id;
                rsp_err   <= 1'b1;
                err_count <= sat_inc16(err_count);
            end
        end
    end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16: maximum ACCESS-phase cycles before a transfer is aborted; legal range 2..255.
REQ-002 apb_clk  in  1  the single clock for all logic.
REQ-003 apb_resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 req_valid  in  2  per-requester request valid, index 0 and index 1.
REQ-005 req_ready  out  2  per-requester accept; a transfer is accepted when req_valid[i] and req_ready[i] are both high.
REQ-006 req_write  in  2  per-requester direction: 1 write, 0 read.
REQ-007 req_addr  in  64  packed addresses; [31:0] requester 0, [63:32] requester 1.
REQ-008 req_wdata  in  64  packed write data, same packing as req_addr.
REQ-009 rsp_valid  out  1  one-cycle completion pulse.
REQ-010 rsp_id  out  1  requester index of the completing transfer.
REQ-011 rsp_err  out  1  completion error: pslverr or timeout.
REQ-012 rsp_rdata  out  32  read data; 0 for writes and for timeouts.
REQ-013 apb_paddr, apb_pwdata  out  32 each  APB address and write data.
REQ-014 apb_psel, apb_penable, apb_pwrite  out  1 each  APB control.
REQ-015 apb_prdata  in  32, apb_pready  in  1, apb_pslverr  in  1  APB completer response.
REQ-016 err_count  out  16  count of error completions, saturating at 0xFFFF.

Function
REQ-017 FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP when any req_valid is high.
- SETUP -> ACCESS unconditionally after one cycle.
- ACCESS -> IDLE on pready or on timeout.
REQ-018 In IDLE, req_ready SHALL be driven combinationally, one-hot, for the granted requester only; it SHALL be 0 in every other state.
REQ-019 Grant rule:
- With only one requester valid, that requester is granted.
- With both valid, the requester not granted last time wins (round-robin).
- After reset, requester 0 wins the first tie.
REQ-020 On acceptance, the granted requester's addr, wdata, write and index SHALL be registered.
- apb_paddr, apb_pwdata and apb_pwrite SHALL hold those values, stable through SETUP and ACCESS.
REQ-021 SETUP: psel=1, penable=0. ACCESS: psel=1, penable=1. IDLE: psel=0, penable=0.
REQ-022 pready, pslverr and prdata SHALL be sampled only in ACCESS.
REQ-023 Normal completion (pready high in ACCESS): the next cycle SHALL have rsp_valid=1, rsp_err=pslverr and rsp_rdata=prdata (read) or 0 (write), with the registered rsp_id.
REQ-024 Timeout:
- An ACCESS-cycle counter starts at 1 on ACCESS entry.
- If the counter equals TIMEOUT_CYCLES and pready is low, the block SHALL return to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0.
- pready arriving in that same cycle counts as normal completion.
REQ-025 rsp_valid SHALL be high for exactly one cycle per accepted request; there is no backpressure on responses.
REQ-026 Minimum spacing is 3 cycles per transfer (IDLE, SETUP, ACCESS); a new grant may occur in the IDLE cycle that carries rsp_valid.
REQ-027 err_count SHALL increment on every completion with rsp_err=1 and SHALL hold at 0xFFFF.
REQ-028 req_valid dropping without a handshake is legal and SHALL NOT affect state.

Reset
REQ-029 Asserting apb_resetn low SHALL immediately force:
- state IDLE; all outputs 0, including psel, penable, req_ready, rsp_valid and err_count;
- round-robin pointer "last granted = 1".
REQ-030 Reset during SETUP or ACCESS SHALL abandon the transfer with no rsp_valid; operation resumes on the first apb_clk edge after deassertion.

Structure
REQ-031 Package apb_ctrl_pkg SHALL hold the state enumeration, NUM_REQ=2, ADDR_W=32, DATA_W=32 and the TIMEOUT_CYCLES default.
REQ-032 Round-robin selection SHALL be the sub-module apb_rr_arbiter.
- Inputs: req[1:0], last-grant pointer.
- Output: one-hot grant.
- Combinational; the pointer register stays in the parent.

Verification
REQ-033 Single write: req 0, write, addr 0x1000, wdata 0xDEADBEEF, pready high on the first ACCESS cycle.
- Response: psel high for 2 cycles, penable high for 1.
- rsp_valid one cycle later with rsp_id=0, rsp_err=0, rsp_rdata=0.
REQ-034 Read with wait states: req 1 reads 0x2004, pready low 3 cycles, prdata 0x12345678.
- Response: ACCESS lasts 4 cycles; rsp_rdata=0x12345678, rsp_id=1.
REQ-035 Contention: both requesters valid continuously for 4 transfers.
- Response: grant order 0,1,0,1; each rsp_id matches; transfers spaced 3 cycles apart.
REQ-036 Timeout: pready held low, TIMEOUT_CYCLES=16.
- Response: exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, err_count=1.
REQ-037 pslverr=1 with pready: rsp_err=1, err_count increments; next transfer proceeds normally.
REQ-038 Reset asserted mid-ACCESS: psel and penable drop to 0 immediately with no rsp_valid; after release, req 0 wins the first tie.
